multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mc_defs.sv | 132 +++++++++++++
 rtl/mc_opdecode.sv | 35 +++
 rtl/multicycle_control.sv | 133 +++++++++++++
 tb/tb_multicycle_control.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_defs.sv
// Shared definitions for the multicycle control path: opcodes, FSM state
// encodings, datapath select codes and the per-state control word.
package mc_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEN   = 6'b000110;
    localparam logic [5:0] OP_BVF   = 6'b000101;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] BR_EQ = 2'b00;
    localparam logic [1:0] BR_NE = 2'b01;
    localparam logic [1:0] BR_VF = 2'b10;

    // Bit positions of the one-hot instruction class.
    localparam int CLS_W    = 7;
    localparam int CLS_R    = 0;
    localparam int CLS_LW   = 1;
    localparam int CLS_SW   = 2;
    localparam int CLS_BR   = 3;
    localparam int CLS_J    = 4;
    localparam int CLS_ADDI = 5;
    localparam int CLS_ILL  = 6;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrca;
        logic       regwrite;
        logic       regdst;
        logic [1:0] pcsource;
        logic [1:0] aluop;
        logic [1:0] alusrcb;
    } ctrl_t;

    // State-only part of the control word; the mem_ready-gated FETCH strobes
    // (pcwrite, irwrite) and brtype are added by the FSM itself.
    function automatic ctrl_t ctrl_for_state(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.memread = 1'b1;
                c.alusrcb = SRCB_FOUR;
                c.aluop   = ALUOP_ADD;
                c.pcsource = PCSRC_ALU;
            end
            S_DECODE: begin
                c.alusrcb = SRCB_IMMSH;
                c.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            S_EXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REG;
                c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            S_ADDIWB: begin
                c.regwrite = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca     = 1'b1;
                c.alusrcb     = SRCB_REG;
                c.aluop       = ALUOP_SUB;
                c.pcwritecond = 1'b1;
                c.pcsource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                c.pcwrite  = 1'b1;
                c.pcsource = PCSRC_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_opdecode.sv
// Opcode classifier: one-hot instruction class plus branch condition type.
module mc_opdecode
    import mc_defs::*;
(
    input  logic [5:0]       opcode_i,
    output logic [CLS_W-1:0] cls_o,
    output logic [1:0]       brtype_o
);

    always_comb begin
        cls_o    = '0;
        brtype_o = BR_EQ;
        case (opcode_i)
            OP_RTYPE: cls_o[CLS_R]    = 1'b1;
            OP_LW:    cls_o[CLS_LW]   = 1'b1;
            OP_SW:    cls_o[CLS_SW]   = 1'b1;
            OP_J:     cls_o[CLS_J]    = 1'b1;
            OP_ADDI:  cls_o[CLS_ADDI] = 1'b1;
            OP_BEQ: begin
                cls_o[CLS_BR] = 1'b1;
                brtype_o      = BR_EQ;
            end
            OP_BEN: begin
                cls_o[CLS_BR] = 1'b1;
                brtype_o      = BR_NE;
            end
            OP_BVF: begin
                cls_o[CLS_BR] = 1'b1;
                brtype_o      = BR_VF;
            end
            default:  cls_o[CLS_ILL]  = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with registered, state-decoded outputs.
// Define MULTICYCLE_PERF_EN to add the 32-bit 'retired' instruction counter.
module multicycle_control
    import mc_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pcwrite,
    output logic        pcwritecond,
    output logic        iord,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        irwrite,
    output logic        alusrca,
    output logic        regwrite,
    output logic        regdst,
    output logic [1:0]  pcsource,
    output logic [1:0]  aluop,
    output logic [1:0]  alusrcb,
    output logic [1:0]  brtype,
    output logic        illegal,
`ifdef MULTICYCLE_PERF_EN
    output logic [31:0] retired,
`endif
    output logic [3:0]  state
);

    state_e           state_q, state_d;
    ctrl_t            ctrl_q;
    logic [1:0]       brtype_q;
    logic             illegal_q, illegal_d;
    logic [CLS_W-1:0] cls;
    logic [1:0]       dec_brtype;
    logic             in_fetch;

    mc_opdecode u_opdecode (
        .opcode_i (opcode),
        .cls_o    (cls),
        .brtype_o (dec_brtype)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (cls[CLS_ILL]) begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end else if (cls[CLS_LW] || cls[CLS_SW]) state_d = S_MEMADR;
                else if (cls[CLS_R])    state_d = S_EXEC;
                else if (cls[CLS_BR])   state_d = S_BRANCH;
                else if (cls[CLS_J])    state_d = S_JUMP;
                else if (cls[CLS_ADDI]) state_d = S_ADDIEX;
                else                    state_d = S_FETCH;
            end
            S_MEMADR: state_d = cls[CLS_LW] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_MEMWB:  state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Control word and brtype are decoded from the next state so they are
    // registered alongside it and stay stable for the whole state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            ctrl_q    <= ctrl_for_state(S_FETCH);
            brtype_q  <= BR_EQ;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_for_state(state_d);
            brtype_q  <= (state_d == S_BRANCH) ? dec_brtype : BR_EQ;
            illegal_q <= illegal_d;
        end
    end

`ifdef MULTICYCLE_PERF_EN
    logic [31:0] retired_q, retired_d;
    logic        retire_event;

    // An instruction retires when control returns to FETCH from its last
    // state; DECODE->FETCH only happens for an illegal opcode.
    assign retire_event = (state_d == S_FETCH) && (state_q != S_FETCH) &&
                          (state_q != S_DECODE);

    always_comb begin
        retired_d = retired_q;
        if (retire_event) retired_d = retired_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) retired_q <= '0;
        else       retired_q <= retired_d;
    end

    assign retired = reset ? 32'd0 : retired_q;
`endif

    // Reset masks everything immediately so a pending access is dropped
    // without a write strobe; memread stays up to restart the fetch.
    assign in_fetch    = (state_q == S_FETCH);
    assign pcwrite     = ~reset & (ctrl_q.pcwrite | (in_fetch & mem_ready));
    assign irwrite     = ~reset & in_fetch & mem_ready;
    assign pcwritecond = ~reset & ctrl_q.pcwritecond;
    assign iord        = ~reset & ctrl_q.iord;
    assign memread     =  reset | ctrl_q.memread;
    assign memwrite    = ~reset & ctrl_q.memwrite;
    assign memtoreg    = ~reset & ctrl_q.memtoreg;
    assign alusrca     = ~reset & ctrl_q.alusrca;
    assign regwrite    = ~reset & ctrl_q.regwrite;
    assign regdst      = ~reset & ctrl_q.regdst;
    assign pcsource    = reset ? 2'b00 : ctrl_q.pcsource;
    assign aluop       = reset ? 2'b00 : ctrl_q.aluop;
    assign alusrcb     = reset ? 2'b00 : ctrl_q.alusrcb;
    assign brtype      = reset ? 2'b00 : brtype_q;
    assign illegal     = ~reset & illegal_q;
    assign state       = reset ? S_FETCH : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control; expected per-cycle states and
// controls are queued when an instruction is scheduled and popped per cycle.
module tb_multicycle_control;
    import mc_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
    logic        irwrite, alusrca, regwrite, regdst;
    logic [1:0]  pcsource, aluop, alusrcb, brtype;
    logic        illegal;
    logic [3:0]  state;
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] retired;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Entry layout: {opcode[13:8], brtype[7:6], illegal[5], mem_ready[4], state[3:0]}
    localparam int W = 14;
    logic [W-1:0] exp_q[$];

    logic [15:0] obs;
    assign obs = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
                  alusrca, regwrite, regdst, pcsource, aluop, alusrcb};

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .pcwrite     (pcwrite),
        .pcwritecond (pcwritecond),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .memtoreg    (memtoreg),
        .irwrite     (irwrite),
        .alusrca     (alusrca),
        .regwrite    (regwrite),
        .regdst      (regdst),
        .pcsource    (pcsource),
        .aluop       (aluop),
        .alusrcb     (alusrcb),
        .brtype      (brtype),
        .illegal     (illegal),
`ifdef MULTICYCLE_PERF_EN
        .retired     (retired),
`endif
        .state       (state)
    );

    // Expected control vector for a state, written from the state table.
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic rdy);
        logic pcw, pcwc, io, mrd, mwr, m2r, irw, sa, rw, rd;
        logic [1:0] ps, ao, sb;
        {pcw, pcwc, io, mrd, mwr, m2r, irw, sa, rw, rd} = '0;
        ps = 2'b00; ao = 2'b00; sb = 2'b00;
        case (st)
            S_FETCH:  begin mrd = 1'b1; irw = rdy; pcw = rdy; sb = 2'b01; end
            S_DECODE: sb = 2'b11;
            S_MEMADR, S_ADDIEX: begin sa = 1'b1; sb = 2'b10; end
            S_MEMRD:  begin mrd = 1'b1; io = 1'b1; end
            S_MEMWR:  begin mwr = 1'b1; io = 1'b1; end
            S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
            S_EXEC:   begin sa = 1'b1; ao = 2'b10; end
            S_ALUWB:  begin rw = 1'b1; rd = 1'b1; end
            S_ADDIWB: rw = 1'b1;
            S_BRANCH: begin sa = 1'b1; ao = 2'b01; pcwc = 1'b1; ps = 2'b01; end
            S_JUMP:   begin pcw = 1'b1; ps = 2'b10; end
            default:  ;
        endcase
        return {pcw, pcwc, io, mrd, mwr, m2r, irw, sa, rw, rd, ps, ao, sb};
    endfunction

    task automatic push_step(input logic [3:0] st, input logic rdy, input logic ill,
                             input logic [1:0] br, input logic [5:0] op);
        exp_q.push_back({op, br, ill, rdy, st});
    endtask

    // Queue the expected state walk of one instruction, with up to max_stall
    // random wait cycles wherever memory is accessed.
    task automatic push_instr(input logic [5:0] op, input int max_stall);
        int n;
        n = $urandom_range(max_stall, 0);
        repeat (n) push_step(S_FETCH, 1'b0, 1'b0, 2'b00, op);
        push_step(S_FETCH, 1'b1, 1'b0, 2'b00, op);
        push_step(S_DECODE, 1'b1, 1'b0, 2'b00, op);
        n = $urandom_range(max_stall, 0);
        case (op)
            6'b100011: begin
                push_step(S_MEMADR, 1'b1, 1'b0, 2'b00, op);
                repeat (n) push_step(S_MEMRD, 1'b0, 1'b0, 2'b00, op);
                push_step(S_MEMRD, 1'b1, 1'b0, 2'b00, op);
                push_step(S_MEMWB, 1'b1, 1'b0, 2'b00, op);
            end
            6'b101011: begin
                push_step(S_MEMADR, 1'b1, 1'b0, 2'b00, op);
                repeat (n) push_step(S_MEMWR, 1'b0, 1'b0, 2'b00, op);
                push_step(S_MEMWR, 1'b1, 1'b0, 2'b00, op);
            end
            6'b000000: begin
                push_step(S_EXEC, 1'b1, 1'b0, 2'b00, op);
                push_step(S_ALUWB, 1'b1, 1'b0, 2'b00, op);
            end
            6'b001000: begin
                push_step(S_ADDIEX, 1'b1, 1'b0, 2'b00, op);
                push_step(S_ADDIWB, 1'b1, 1'b0, 2'b00, op);
            end
            6'b000100: push_step(S_BRANCH, 1'b1, 1'b0, 2'b00, op);
            6'b000110: push_step(S_BRANCH, 1'b1, 1'b0, 2'b01, op);
            6'b000101: push_step(S_BRANCH, 1'b1, 1'b0, 2'b10, op);
            6'b000010: push_step(S_JUMP, 1'b1, 1'b0, 2'b00, op);
            default: ;
        endcase
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'b100011;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (state !== S_FETCH) begin
            miscompares++; $display("FAIL reset_state: got %0d expected %0d", state, S_FETCH);
        end
        vectors++;
        if (obs !== 16'h1000 || illegal !== 1'b0 || brtype !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_outputs: got ctrl=%h ill=%b br=%b expected ctrl=1000 ill=0 br=00",
                     obs, illegal, brtype);
        end
        reset = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (state !== S_FETCH || obs !== exp_ctrl(S_FETCH, 1'b0)) begin
            miscompares++;
            $display("FAIL post_reset_fetch: got state=%0d ctrl=%h expected state=0 ctrl=%h",
                     state, obs, exp_ctrl(S_FETCH, 1'b0));
        end
`ifdef MULTICYCLE_PERF_EN
        vectors++;
        if (retired !== 32'd0) begin
            miscompares++; $display("FAIL reset_retired: got %0h expected 0", retired);
        end
`endif
    endtask

    task automatic test_lw();
        logic [W-1:0] e;
        push_instr(6'b100011, 0);
        push_step(S_FETCH, 1'b0, 1'b0, 2'b00, 6'b100011);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            opcode = e[13:8]; mem_ready = e[4];
            #1;
            vectors++;
            if (state !== e[3:0] || obs !== exp_ctrl(e[3:0], e[4])) begin
                miscompares++;
                $display("FAIL lw_step: got state=%0d ctrl=%h expected state=%0d ctrl=%h",
                         state, obs, e[3:0], exp_ctrl(e[3:0], e[4]));
            end
            vectors++;
            if (regwrite !== (e[3:0] == S_MEMWB) || memtoreg !== (e[3:0] == S_MEMWB)) begin
                miscompares++;
                $display("FAIL lw_writeback: got regwrite=%b memtoreg=%b in state %0d",
                         regwrite, memtoreg, e[3:0]);
            end
            if (exp_q.size() > 0) begin @(posedge clk); @(negedge clk); end
        end
    endtask

    task automatic test_sw_stall();
        logic [W-1:0] e;
        int wr_cycles = 0;
        push_step(S_FETCH, 1'b1, 1'b0, 2'b00, 6'b101011);
        push_step(S_DECODE, 1'b1, 1'b0, 2'b00, 6'b101011);
        push_step(S_MEMADR, 1'b1, 1'b0, 2'b00, 6'b101011);
        repeat (3) push_step(S_MEMWR, 1'b0, 1'b0, 2'b00, 6'b101011);
        push_step(S_MEMWR, 1'b1, 1'b0, 2'b00, 6'b101011);
        push_step(S_FETCH, 1'b0, 1'b0, 2'b00, 6'b101011);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            opcode = e[13:8]; mem_ready = e[4];
            #1;
            if (memwrite === 1'b1) wr_cycles++;
            vectors++;
            if (state !== e[3:0] || obs !== exp_ctrl(e[3:0], e[4])) begin
                miscompares++;
                $display("FAIL sw_step: got state=%0d ctrl=%h expected state=%0d ctrl=%h",
                         state, obs, e[3:0], exp_ctrl(e[3:0], e[4]));
            end
            if (exp_q.size() > 0) begin @(posedge clk); @(negedge clk); end
        end
        vectors++;
        if (wr_cycles != 4) begin
            miscompares++; $display("FAIL sw_memwrite_cycles: got %0d expected 4", wr_cycles);
        end
    endtask

    task automatic test_branches();
        logic [W-1:0] e;
        logic [5:0] ops[3];
        ops[0] = 6'b000100; ops[1] = 6'b000110; ops[2] = 6'b000101;
        for (int i = 0; i < 3; i++) push_instr(ops[i], 0);
        push_step(S_FETCH, 1'b0, 1'b0, 2'b00, 6'b000101);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            opcode = e[13:8]; mem_ready = e[4];
            #1;
            vectors++;
            if (state !== e[3:0] || obs !== exp_ctrl(e[3:0], e[4])) begin
                miscompares++;
                $display("FAIL branch_step: got state=%0d ctrl=%h expected state=%0d ctrl=%h",
                         state, obs, e[3:0], exp_ctrl(e[3:0], e[4]));
            end
            vectors++;
            if (brtype !== e[7:6]) begin
                miscompares++;
                $display("FAIL branch_brtype: got %b expected %b (op %b state %0d)",
                         brtype, e[7:6], e[13:8], e[3:0]);
            end
            if (exp_q.size() > 0) begin @(posedge clk); @(negedge clk); end
        end
    endtask

    task automatic test_illegal();
        logic [W-1:0] e;
        int ill_cycles = 0;
`ifdef MULTICYCLE_PERF_EN
        logic [31:0] before;
        before = retired;
`endif
        push_step(S_FETCH, 1'b1, 1'b0, 2'b00, 6'b111111);
        push_step(S_DECODE, 1'b1, 1'b0, 2'b00, 6'b111111);
        push_step(S_FETCH, 1'b0, 1'b1, 2'b00, 6'b111111);
        push_step(S_FETCH, 1'b0, 1'b0, 2'b00, 6'b111111);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            opcode = e[13:8]; mem_ready = e[4];
            #1;
            if (illegal === 1'b1) ill_cycles++;
            vectors++;
            if (state !== e[3:0] || illegal !== e[5]) begin
                miscompares++;
                $display("FAIL illegal_step: got state=%0d illegal=%b expected state=%0d illegal=%b",
                         state, illegal, e[3:0], e[5]);
            end
            if (exp_q.size() > 0) begin @(posedge clk); @(negedge clk); end
        end
        vectors++;
        if (ill_cycles != 1) begin
            miscompares++; $display("FAIL illegal_pulse_len: got %0d expected 1", ill_cycles);
        end
`ifdef MULTICYCLE_PERF_EN
        vectors++;
        if (retired !== before) begin
            miscompares++; $display("FAIL illegal_retired: got %0h expected %0h", retired, before);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e;
        logic [5:0] ops[8];
        int n_instr = 16;
`ifdef MULTICYCLE_PERF_EN
        logic [31:0] before;
        before = retired;
`endif
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
        ops[4] = 6'b000010; ops[5] = 6'b001000; ops[6] = 6'b000110; ops[7] = 6'b000101;
        for (int i = 0; i < n_instr; i++) push_instr(ops[$urandom_range(7, 0)], 2);
        push_step(S_FETCH, 1'b0, 1'b0, 2'b00, 6'b000000);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            opcode = e[13:8]; mem_ready = e[4];
            #1;
            vectors++;
            if (state !== e[3:0] || obs !== exp_ctrl(e[3:0], e[4]) || brtype !== e[7:6] ||
                illegal !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_step: got state=%0d ctrl=%h br=%b ill=%b expected state=%0d ctrl=%h br=%b ill=0",
                         state, obs, brtype, illegal, e[3:0], exp_ctrl(e[3:0], e[4]), e[7:6]);
            end
            if (exp_q.size() > 0) begin @(posedge clk); @(negedge clk); end
        end
`ifdef MULTICYCLE_PERF_EN
        vectors++;
        if (retired !== before + 32'(n_instr)) begin
            miscompares++;
            $display("FAIL b2b_retired: got %0h expected %0h", retired, before + 32'(n_instr));
        end
`endif
    endtask

    task automatic test_reset_mid_memrd();
        logic [W-1:0] e;
        push_step(S_FETCH, 1'b1, 1'b0, 2'b00, 6'b100011);
        push_step(S_DECODE, 1'b1, 1'b0, 2'b00, 6'b100011);
        push_step(S_MEMADR, 1'b1, 1'b0, 2'b00, 6'b100011);
        push_step(S_MEMRD, 1'b0, 1'b0, 2'b00, 6'b100011);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            opcode = e[13:8]; mem_ready = e[4];
            #1;
            vectors++;
            if (state !== e[3:0] || obs !== exp_ctrl(e[3:0], e[4])) begin
                miscompares++;
                $display("FAIL rst_memrd_step: got state=%0d ctrl=%h expected state=%0d ctrl=%h",
                         state, obs, e[3:0], exp_ctrl(e[3:0], e[4]));
            end
            if (exp_q.size() > 0) begin @(posedge clk); @(negedge clk); end
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (memwrite !== 1'b0 || memread !== 1'b1 || iord !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_memrd_mask: got memwrite=%b memread=%b iord=%b expected 0 1 0",
                     memwrite, memread, iord);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        vectors++;
        if (state !== S_FETCH || memwrite !== 1'b0 || obs !== exp_ctrl(S_FETCH, 1'b0)) begin
            miscompares++;
            $display("FAIL rst_memrd_after: got state=%0d ctrl=%h expected state=0 ctrl=%h",
                     state, obs, exp_ctrl(S_FETCH, 1'b0));
        end
`ifdef MULTICYCLE_PERF_EN
        vectors++;
        if (retired !== 32'd0) begin
            miscompares++; $display("FAIL rst_memrd_retired: got %0h expected 0", retired);
        end
`endif
    endtask

`ifdef MULTICYCLE_PERF_EN
    task automatic test_perf_wrap();
        logic [W-1:0] e;
        dut.retired_q = 32'hFFFF_FFFF;
        push_instr(6'b000010, 0);
        push_step(S_FETCH, 1'b0, 1'b0, 2'b00, 6'b000010);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            opcode = e[13:8]; mem_ready = e[4];
            #1;
            vectors++;
            if (state !== e[3:0] || obs !== exp_ctrl(e[3:0], e[4])) begin
                miscompares++;
                $display("FAIL wrap_step: got state=%0d ctrl=%h expected state=%0d ctrl=%h",
                         state, obs, e[3:0], exp_ctrl(e[3:0], e[4]));
            end
            if (e[3:0] == S_JUMP) begin
                vectors++;
                if (retired !== 32'hFFFF_FFFF) begin
                    miscompares++; $display("FAIL wrap_pre: got %0h expected ffffffff", retired);
                end
            end
            if (exp_q.size() > 0) begin @(posedge clk); @(negedge clk); end
        end
        vectors++;
        if (retired !== 32'd0) begin
            miscompares++; $display("FAIL wrap_post: got %0h expected 0", retired);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b0; opcode = 6'b000000;
        test_reset();
        test_lw();
        test_sw_stall();
        test_branches();
        test_illegal();
        test_back_to_back();
        test_reset_mid_memrd();
`ifdef MULTICYCLE_PERF_EN
        test_perf_wrap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
